// File: rtl/data_cache_wt.sv
// data_cache_wt: direct-mapped write-through no-write-allocate data cache with big-endian byte lanes
module data_cache_wt #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int SET_WIDTH = 8,
    parameter int TAG_WIDTH = ADDRESS_WIDTH - SET_WIDTH - 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     re,
    input  logic                     we,
    input  logic [1:0]               AccessSize,
    input  logic [ADDRESS_WIDTH-1:0] Address,
    input  logic [DATA_WIDTH-1:0]    WriteData,
    output logic [DATA_WIDTH-1:0]    ReadData,
    output logic                     Stall,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [3:0]               mem_be,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    input  logic [DATA_WIDTH-1:0]    mem_rdata,
    input  logic                     mem_ack,
    output logic [CNT_WIDTH-1:0]     hit_count,
    output logic [CNT_WIDTH-1:0]     miss_count
);
    localparam int SETS = 1 << SET_WIDTH;
    typedef enum logic [1:0] {IDLE, FETCH, WRITE, WDONE} state_t;
    state_t state;
    logic [SETS-1:0] valid;
    logic [TAG_WIDTH-1:0] tag_mem [SETS];
    logic [31:0] data_mem [SETS];
    logic refill;
    logic [SET_WIDTH-1:0] idx;
    logic [TAG_WIDTH-1:0] tag;
    logic [1:0] off;
    logic [31:0] line, sel, wdata, merged;
    logic [7:0] byte_sel;
    logic [3:0] be;
    logic hit;
    always_comb begin
        idx = Address[SET_WIDTH+1:2];
        tag = Address[ADDRESS_WIDTH-1:SET_WIDTH+2];
        off = Address[1:0];
        line = data_mem[idx];
        hit = valid[idx] && tag_mem[idx] == tag;
        byte_sel = off == 2'd0 ? line[31:24] : off == 2'd1 ? line[23:16] : off == 2'd2 ? line[15:8] : line[7:0];
        sel = AccessSize == 2'b00 ? {24'b0, byte_sel} :
              AccessSize == 2'b01 ? {16'b0, off[1] ? line[15:0] : line[31:16]} : line;
        wdata = AccessSize == 2'b00 ? {4{WriteData[7:0]}} :
                AccessSize == 2'b01 ? {2{WriteData[15:0]}} : WriteData[31:0];
        be = AccessSize == 2'b00 ? 4'b1000 >> off :
             AccessSize == 2'b01 ? (off[1] ? 4'b0011 : 4'b1100) : 4'b1111;
        merged = line;
        for (int i = 0; i < 4; i++)
            if (mem_be[i]) merged[8*i +: 8] = mem_wdata[8*i +: 8];
        ReadData = state == IDLE && re && !we && hit ? sel : '0;
        Stall = state == FETCH || state == WRITE || (state == IDLE && (we || (re && !hit)));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            valid <= '0;
            refill <= 1'b0;
            mem_req <= 1'b0;
            mem_we <= 1'b0;
            mem_be <= '0;
            mem_addr <= '0;
            mem_wdata <= '0;
            hit_count <= '0;
            miss_count <= '0;
        end else begin
            refill <= 1'b0;
            case (state)
                IDLE: begin
                    if (we) begin
                        state <= WRITE;
                        mem_req <= 1'b1;
                        mem_we <= 1'b1;
                        mem_be <= be;
                        mem_addr <= {Address[ADDRESS_WIDTH-1:2], 2'b00};
                        mem_wdata <= wdata;
                    end else if (re && !hit) begin
                        state <= FETCH;
                        mem_req <= 1'b1;
                        mem_we <= 1'b0;
                        mem_be <= 4'b1111;
                        mem_addr <= {Address[ADDRESS_WIDTH-1:2], 2'b00};
                        if (~&miss_count) miss_count <= miss_count + CNT_WIDTH'(1);
                    end else if (re && !refill && ~&hit_count) begin
                        hit_count <= hit_count + CNT_WIDTH'(1);
                    end
                end
                FETCH: begin
                    if (mem_ack) begin
                        state <= IDLE;
                        valid[idx] <= 1'b1;
                        tag_mem[idx] <= tag;
                        data_mem[idx] <= mem_rdata[31:0];
                        refill <= 1'b1;
                        mem_req <= 1'b0;
                        mem_be <= '0;
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        state <= WDONE;
                        if (hit) data_mem[idx] <= merged;
                        mem_req <= 1'b0;
                        mem_we <= 1'b0;
                        mem_be <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_data_cache_wt.sv
// tb_data_cache_wt: table-driven scoreboard bench for data_cache_wt with a latency-controlled memory model
module tb_data_cache_wt;
    logic clk = 1'b0;
    logic rst, re, we, mem_req, mem_we, mem_ack, Stall;
    logic [1:0] AccessSize;
    logic [31:0] Address, WriteData, ReadData, mem_addr, mem_wdata, mem_rdata, hit_count, miss_count;
    logic [3:0] mem_be;
    int checks = 0;
    int errors = 0;
    typedef struct {
        string nm;
        logic w;
        logic [1:0] sz;
        logic [31:0] a, wd;
        int lat;
        logic [31:0] rd;
        int st;
        logic [3:0] be;
        logic [31:0] mwd;
        int hits, misses;
    } vec_t;
    typedef struct {
        logic [31:0] rd, wd, addr;
        int st;
        logic [3:0] be;
        logic mwe, req, ok;
    } obs_t;
    vec_t tbl[$];
    vec_t sb[$];
    logic [31:0] bmem [logic [29:0]];

    data_cache_wt dut (
        .clk(clk), .rst(rst), .re(re), .we(we), .AccessSize(AccessSize), .Address(Address),
        .WriteData(WriteData), .ReadData(ReadData), .Stall(Stall), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        return bmem.exists(a[31:2]) ? bmem[a[31:2]] : 32'h0;
    endfunction

    task automatic wr_word(input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        logic [31:0] w;
        w = rd_word(a);
        for (int k = 0; k < 4; k++)
            if (b[k]) w[8*k +: 8] = d[8*k +: 8];
        bmem[a[31:2]] = w;
    endtask

    function automatic vec_t v(input string nm, input logic w, input logic [1:0] sz, input logic [31:0] a, wd,
                               input int lat, input logic [31:0] rd, input int st, input logic [3:0] be,
                               input logic [31:0] mwd, input int hits, misses);
        vec_t r;
        r.nm = nm; r.w = w; r.sz = sz; r.a = a; r.wd = wd; r.lat = lat; r.rd = rd;
        r.st = st; r.be = be; r.mwd = mwd; r.hits = hits; r.misses = misses;
        return r;
    endfunction

    // re stays high on writes too, so every store also exercises write-over-read priority
    task automatic access(input logic w, input logic [1:0] sz, input logic [31:0] a, wd, input int lat, output obs_t o);
        int n, guard;
        @(negedge clk);
        we = w; re = 1'b1; AccessSize = sz; Address = a; WriteData = wd;
        #1;
        o.st = 0; o.be = '0; o.wd = '0; o.addr = '0; o.mwe = 1'b0;
        n = 0; guard = 0;
        while (Stall && guard < 100) begin
            o.st++;
            if (mem_req) begin
                n++;
                if (n == lat) begin
                    o.be = mem_be; o.wd = mem_wdata; o.addr = mem_addr; o.mwe = mem_we;
                    mem_rdata = rd_word(mem_addr);
                    if (mem_we) wr_word(mem_addr, mem_be, mem_wdata);
                    mem_ack = 1'b1;
                end
            end
            @(negedge clk);
            mem_ack = 1'b0;
            mem_rdata = '0;
            #1;
            guard++;
        end
        o.ok = guard < 100;
        o.rd = ReadData;
        o.req = mem_req;
    endtask

    task automatic idle();
        @(negedge clk);
        re = 1'b0; we = 1'b0;
        #1;
    endtask

    initial begin
        obs_t o;
        vec_t e;
        rst = 1'b1; re = 1'b0; we = 1'b0; AccessSize = 2'b10; Address = '0; WriteData = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        bmem[30'h4000] = 32'hA1B2C3D4;
        bmem[30'h4100] = 32'h0BADF00D;
        bmem[30'hC000] = 32'hCAFEBABE;
        tbl.push_back(v("rd_miss",   0, 2'd2, 32'h0001_0000, 0, 3, 32'hA1B2C3D4, 4, 0, 0, 0, 1));
        tbl.push_back(v("rd_hit",    0, 2'd2, 32'h0001_0000, 0, 1, 32'hA1B2C3D4, 0, 0, 0, 1, 1));
        tbl.push_back(v("byte0",     0, 2'd0, 32'h0001_0000, 0, 1, 32'h000000A1, 0, 0, 0, 2, 1));
        tbl.push_back(v("byte1",     0, 2'd0, 32'h0001_0001, 0, 1, 32'h000000B2, 0, 0, 0, 3, 1));
        tbl.push_back(v("byte2",     0, 2'd0, 32'h0001_0002, 0, 1, 32'h000000C3, 0, 0, 0, 4, 1));
        tbl.push_back(v("byte3",     0, 2'd0, 32'h0001_0003, 0, 1, 32'h000000D4, 0, 0, 0, 5, 1));
        tbl.push_back(v("half0",     0, 2'd1, 32'h0001_0000, 0, 1, 32'h0000A1B2, 0, 0, 0, 6, 1));
        tbl.push_back(v("half2",     0, 2'd1, 32'h0001_0002, 0, 1, 32'h0000C3D4, 0, 0, 0, 7, 1));
        tbl.push_back(v("half1",     0, 2'd1, 32'h0001_0001, 0, 1, 32'h0000A1B2, 0, 0, 0, 8, 1));
        tbl.push_back(v("word_off3", 0, 2'd2, 32'h0001_0003, 0, 1, 32'hA1B2C3D4, 0, 0, 0, 9, 1));
        tbl.push_back(v("size11",    0, 2'd3, 32'h0001_0000, 0, 1, 32'hA1B2C3D4, 0, 0, 0, 10, 1));
        tbl.push_back(v("st_byte",   1, 2'd0, 32'h0001_0001, 32'hFFFFFF5E, 2, 0, 3, 4'b0100, 32'h5E5E5E5E, 10, 1));
        tbl.push_back(v("rd_merged", 0, 2'd2, 32'h0001_0000, 0, 1, 32'hA15EC3D4, 0, 0, 0, 11, 1));
        tbl.push_back(v("st_half",   1, 2'd1, 32'h0001_0002, 32'h1234BEEF, 1, 0, 2, 4'b0011, 32'hBEEFBEEF, 11, 1));
        tbl.push_back(v("rd_merged2",0, 2'd2, 32'h0001_0000, 0, 1, 32'hA15EBEEF, 0, 0, 0, 12, 1));
        tbl.push_back(v("st_miss",   1, 2'd2, 32'h0002_0000, 32'h11223344, 1, 0, 2, 4'b1111, 32'h11223344, 12, 1));
        tbl.push_back(v("rd_kept",   0, 2'd2, 32'h0001_0000, 0, 1, 32'hA15EBEEF, 0, 0, 0, 13, 1));
        tbl.push_back(v("rd_noalloc",0, 2'd2, 32'h0002_0000, 0, 2, 32'h11223344, 3, 0, 0, 13, 2));
        tbl.push_back(v("conflict",  0, 2'd2, 32'h0001_0400, 0, 1, 32'h0BADF00D, 2, 0, 0, 13, 3));
        tbl.push_back(v("reread",    0, 2'd2, 32'h0001_0000, 0, 1, 32'hA15EBEEF, 2, 0, 0, 13, 4));
        tbl.push_back(v("evicted",   0, 2'd2, 32'h0001_0400, 0, 1, 32'h0BADF00D, 2, 0, 0, 13, 5));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_stall", 32'(Stall), 0);
        check("reset_rdata", ReadData, 0);
        check("reset_req", 32'(mem_req), 0);
        check("reset_hits", hit_count, 0);
        check("reset_misses", miss_count, 0);
        for (int i = 0; i < tbl.size(); i++) begin
            sb.push_back(tbl[i]);
            access(tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd, tbl[i].lat, o);
            e = sb.pop_front();
            check({e.nm, "_bound"}, 32'(o.ok), 1);
            check({e.nm, "_stall"}, o.st, e.st);
            if (e.st != 0) check({e.nm, "_addr"}, o.addr, {e.a[31:2], 2'b00});
            if (e.w) begin
                check({e.nm, "_be"}, 32'(o.be), 32'(e.be));
                check({e.nm, "_wdata"}, o.wd, e.mwd);
                check({e.nm, "_mwe"}, 32'(o.mwe), 1);
                check({e.nm, "_req_off"}, 32'(o.req), 0);
            end else begin
                check({e.nm, "_rdata"}, o.rd, e.rd);
            end
            idle();
            check({e.nm, "_idle_stall"}, 32'(Stall), 0);
            check({e.nm, "_idle_rdata"}, ReadData, 0);
            check({e.nm, "_hits"}, hit_count, e.hits);
            check({e.nm, "_misses"}, miss_count, e.misses);
        end
        // reset while a refill is outstanding, then a stray ack
        @(negedge clk);
        we = 1'b0; re = 1'b1; AccessSize = 2'd2; Address = 32'h0003_0000;
        @(negedge clk);
        #1;
        check("abort_req_up", 32'(mem_req), 1);
        rst = 1'b1; re = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_req", 32'(mem_req), 0);
        check("abort_stall", 32'(Stall), 0);
        check("abort_rdata", ReadData, 0);
        check("abort_hits", hit_count, 0);
        check("abort_misses", miss_count, 0);
        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = '0;
        #1;
        check("stray_req", 32'(mem_req), 0);
        check("stray_stall", 32'(Stall), 0);
        access(1'b0, 2'd2, 32'h0003_0000, 0, 1, o);
        check("post_abort_stall", o.st, 2);
        check("post_abort_rdata", o.rd, 32'hCAFEBABE);
        idle();
        check("post_abort_misses", miss_count, 1);
        access(1'b0, 2'd2, 32'h0001_0400, 0, 2, o);
        check("cleared_stall", o.st, 3);
        check("cleared_rdata", o.rd, 32'h0BADF00D);
        idle();
        check("cleared_misses", miss_count, 2);
        check("cleared_hits", hit_count, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_cache_wt.md
Name: data_cache_wt

Overview:
Parametrised successor to the single-cycle data memory. It is a direct-mapped, write-through, no-write-allocate data cache placed between the CPU memory stage and a multi-cycle backing memory. It supports byte, halfword and word accesses with big-endian lane ordering, and raises a stall while misses and write-throughs are in flight. Hit and miss counters are included for performance runs.

Parameters:
ADDRESS_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width; fixed at 32 for lane mapping
SET_WIDTH, 8, log2 of the number of lines; one word per line
TAG_WIDTH, ADDRESS_WIDTH-SET_WIDTH-2, derived tag width
CNT_WIDTH, 32, width of the performance counters

Ports:
clk  in  1  clock; all state changes on the rising edge
rst  in  1  synchronous, active-high reset
re  in  1  CPU read request
we  in  1  CPU write request; takes priority over re
AccessSize  in  2  00 byte, 01 half, 10 word, 11 treated as word
Address  in  ADDRESS_WIDTH  byte address
WriteData  in  DATA_WIDTH  store data, right-aligned
ReadData  out  DATA_WIDTH  load data, zero-extended, right-aligned
Stall  out  1  CPU must hold all request inputs stable while high
mem_req  out  1  backing-memory request
mem_we  out  1  1 = write, 0 = word read
mem_addr  out  ADDRESS_WIDTH  word-aligned address (bits[1:0] = 0)
mem_be  out  4  byte enables; bit3 = lane [31:24] = offset 0
mem_wdata  out  DATA_WIDTH  lane-placed write data
mem_rdata  in  DATA_WIDTH  read data, valid on the mem_ack cycle
mem_ack  in  1  single-cycle completion strobe
hit_count  out  CNT_WIDTH  read hits, saturating
miss_count  out  CNT_WIDTH  read misses, saturating

Behaviour:
- Address split: index = Address[SET_WIDTH+1:2]; tag = Address[ADDRESS_WIDTH-1:SET_WIDTH+2]; offset = Address[1:0].
- Each line holds valid, tag and 32-bit data.
- Lane order: offset 0 maps to bits [31:24], offset 3 to bits [7:0].
- Halfword uses offset[1] only (0 -> [31:16], 1 -> [15:0]); offset[0] is ignored.
- Word accesses ignore offset.
- Read data selection: the byte/half is extracted from the line and zero-extended.
- Store placement: WriteData[7:0] / [15:0] / [31:0] is replicated into the selected lane(s), with mem_be set accordingly: byte 1000>>offset; half 1100 or 0011; word 1111.
- FSM states: IDLE, FETCH, WRITE, WDONE.
- IDLE, re hit (we=0): ReadData is combinational from the line. Stall=0. hit_count++.
- IDLE, re miss: Stall=1 combinationally. Next state FETCH. miss_count++ (once per miss).
- IDLE, we: Stall=1. Next state WRITE.
- Idle output: when no request is present, Stall=0 and ReadData=0.
- FETCH:
  - mem_req=1, mem_we=0, mem_be=1111, mem_addr = word address; Stall=1.
  - On mem_ack: line <= {1, tag, mem_rdata}; next state IDLE.
  - The following cycle is a hit (Stall=0). It is not recounted as a hit.
- WRITE:
  - mem_req=1, mem_we=1, with mem_be/mem_wdata as above; Stall=1.
  - On mem_ack: if the line hits, merge the enabled lanes into the line data. A miss does not allocate.
  - Next state WDONE.
- WDONE: Stall=0 for exactly one cycle so the CPU advances; next state IDLE. The request inputs are not re-examined in this cycle.
- Read miss latency: Stall high for N+1 cycles when mem_ack arrives N cycles after mem_req first rises (N ≥ 1).
- Write latency: Stall high from request until the ack cycle inclusive, then low in WDONE.
- mem_req and all mem_* outputs remain constant from assertion until the mem_ack cycle inclusive, then deassert.
- mem_ack while not in FETCH/WRITE is ignored.
- Counters saturate at all-ones; they are not incremented during reset.
- Reset:
  - All valid bits cleared in one cycle; state=IDLE; mem_req=0; counters=0; Stall follows IDLE rules.
  - Reset mid-FETCH/WRITE aborts the transaction with no line update. A later stray mem_ack is ignored.
- Both re and we high is treated as a write.

Test Plan:
- Reset, then re word @0x0001_0000, mem_rdata=0xA1B2C3D4, ack after 3 cycles -> Stall high 4 cycles; ReadData=0xA1B2C3D4; miss_count=1. Repeat read -> Stall=0 same cycle; hit_count=1.
- After the above, byte reads at offsets 0..3 -> 0xA1, 0xB2, 0xC3, 0xD4 zero-extended; half reads at 0x...00 and 0x...02 -> 0xA1B2 and 0xC3D4, all hits.
- Byte store 0x5E @0x0001_0001 on a cached line -> mem_be=0100, mem_wdata lanes hold 0x5E, Stall drops in WDONE; word read -> 0xA15EC3D4 with no miss.
- Word store 0x11223344 @0x0002_0000 on an uncached line -> memory write issued; next read misses (no allocate) and miss_count increments.
- Conflict: read 0x0001_0000 then 0x0001_0400 (same index, different tag) -> second misses, replaces the line; rereading the first misses again.
- Assert rst during FETCH, then ack 2 cycles later -> mem_req=0, no line valid, Stall=0 while idle; the subsequent read misses normally.
